branch_comp_seq: RTL and testbench

Multi-cycle branch comparator that produces the BrEq/BrLT flags consumed by the PC-select logic.
- Accepts two register operands and an unsigned-compare flag over a valid/ready request.
- Compares CHUNK bits per cycle, MSB chunk first, exiting early on the first differing chunk.
- Returns BrEq/BrLT over a valid/ready response. Sits between the register-file read stage and PC-select.

---
 rtl/branch_comp_seq.sv | 106 ++++++++++
 tb/tb_branch_comp_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/branch_comp_seq.sv
// Multi-cycle branch comparator: walks the operands one CHUNK at a time, MSB chunk
// first, and reports BrEq/BrLT over a valid/ready response handshake.
module branch_comp_seq #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            br_un,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            BrEq,
    output logic            BrLT
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (XLEN % CHUNK != 0) begin : g_bad_width
            $error("branch_comp_seq: XLEN must be an integer multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [IDXW-1:0]  idx;
    logic [CHUNK-1:0] chunk1;
    logic [CHUNK-1:0] chunk2;
    logic             chunk_loaded;
    logic             chunk_last;
    logic [XLEN-1:0]  sign_flip;
    logic [CHUNK-1:0] sel1;
    logic [CHUNK-1:0] sel2;
    logic             advance;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign sign_flip = {~br_un, {(XLEN-1){1'b0}}};

    assign sel1 = op1[idx*CHUNK +: CHUNK];
    assign sel2 = op2[idx*CHUNK +: CHUNK];

    // Chunks are registered before comparison, so the mux and comparator sit in
    // separate cycles; keep fetching while the held chunk pair is still equal.
    assign advance = !chunk_loaded || ((chunk1 == chunk2) && !chunk_last);

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op1          <= '0;
            op2          <= '0;
            idx          <= '0;
            chunk1       <= '0;
            chunk2       <= '0;
            chunk_loaded <= 1'b0;
            chunk_last   <= 1'b0;
            BrEq         <= 1'b0;
            BrLT         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op1          <= rs1 ^ sign_flip;
                        op2          <= rs2 ^ sign_flip;
                        idx          <= IDXW'(NCHUNK - 1);
                        chunk_loaded <= 1'b0;
                        chunk_last   <= 1'b0;
                        state        <= CMP;
                    end
                end
                CMP: begin
                    if (advance) begin
                        chunk1       <= sel1;
                        chunk2       <= sel2;
                        chunk_last   <= (idx == '0);
                        chunk_loaded <= 1'b1;
                        idx          <= idx - 1'b1;
                    end else begin
                        BrEq  <= (chunk1 == chunk2);
                        BrLT  <= (chunk1 < chunk2);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_comp_seq.sv
// Self-checking bench for branch_comp_seq: directed vector table, hand-written
// back-pressure/abort sequences, and randomized back-to-back requests against a model.
module tb_branch_comp_seq;

    localparam int XLEN   = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = XLEN / CHUNK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        un;
        logic        eq;
        logic        lt;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        br_un;
    logic        resp_valid;
    logic        resp_ready;
    logic        BrEq;
    logic        BrLT;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[9];

    branch_comp_seq #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .br_un     (br_un),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .BrEq      (BrEq),
        .BrLT      (BrLT)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain arithmetic compare, latency from the first differing chunk.
    task automatic modelCompare(input logic [31:0] a, input logic [31:0] b, input logic un,
                                output logic eq, output logic lt, output int lat);
        eq  = (a == b);
        lt  = un ? (a < b) : ($signed(a) < $signed(b));
        lat = NCHUNK + 1;
        for (int i = NCHUNK - 1; i >= 0; i--) begin
            if (((a >> ((NCHUNK - 1 - i) * CHUNK)) & 32'hFF) != ((b >> ((NCHUNK - 1 - i) * CHUNK)) & 32'hFF))
                lat = i + 2;
        end
    endtask

    // Called mid-cycle (#1 after a rising edge); returns #1 after the edge that raised resp_valid.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic un,
                                 input bit hold, input logic expEq, input logic expLt,
                                 input int expLat, input string tag);
        int waitCnt = 0;
        int cycles  = 0;
        bit busyOk  = 1'b1;
        rs1 = a;
        rs2 = b;
        br_un = un;
        req_valid = 1'b1;
        while (!req_ready && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        rs1 = $urandom;
        rs2 = $urandom;
        br_un = 1'($urandom);
        while (!resp_valid && cycles < NCHUNK + 10) begin
            if (req_ready) busyOk = 1'b0;
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput({tag, " latency"}, cycles, expLat);
        checkOutput({tag, " busy"}, {31'd0, busyOk}, 32'd1);
        checkOutput({tag, " BrEq"}, {31'd0, BrEq}, {31'd0, expEq});
        checkOutput({tag, " BrLT"}, {31'd0, BrLT}, {31'd0, expLt});
    endtask

    task automatic finishResp(input string tag);
        @(posedge clk); #1;
        checkOutput({tag, " release"}, {30'd0, resp_valid, req_ready}, 32'b01);
    endtask

    initial begin
        logic        mEq;
        logic        mLt;
        int          mLat;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        run;
        int          keep;

        vecs[0] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 5};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 2};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 2};
        vecs[3] = '{32'h0000_0010, 32'h0000_0011, 1'b1, 1'b0, 1'b1, 5};
        vecs[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 2};
        vecs[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 2};
        vecs[6] = '{32'h0001_0000, 32'h0002_0000, 1'b1, 1'b0, 1'b1, 3};
        vecs[7] = '{32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4};
        vecs[8] = '{32'hFFFF_FF00, 32'hFFFF_FF01, 1'b0, 1'b0, 1'b1, 5};

        rst = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        rs1 = '0;
        rs2 = '0;
        br_un = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset state", {29'd0, resp_valid, BrEq, BrLT, req_ready}, 32'b0001);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].un, 1'b0,
                          vecs[i].eq, vecs[i].lt, vecs[i].lat, $sformatf("vec%0d", i));
            finishResp($sformatf("vec%0d", i));
        end

        applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0, 5, "bp");
        resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bp hold%0d", i), {29'd0, resp_valid, BrEq, BrLT, req_ready}, 32'b1100);
        end
        resp_ready = 1'b1;
        finishResp("bp");

        rs1 = '0;
        rs2 = '0;
        br_un = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort state", {29'd0, resp_valid, BrEq, BrLT, req_ready}, 32'b0001);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("abort quiet%0d", i), {30'd0, resp_valid, req_ready}, 32'b01);
        end
        applyStimulus(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 2, "post-abort");
        finishResp("post-abort");

        for (int n = 0; n < 1000; n++) begin
            ra   = $urandom;
            keep = $urandom_range(0, NCHUNK);
            rb   = $urandom;
            if (keep == NCHUNK) rb = ra;
            else if (keep > 0) rb = (ra & ~(32'hFFFF_FFFF >> (keep * CHUNK))) | (rb & (32'hFFFF_FFFF >> (keep * CHUNK)));
            run = 1'($urandom);
            modelCompare(ra, rb, run, mEq, mLt, mLat);
            applyStimulus(ra, rb, run, 1'b1, mEq, mLt, mLat, $sformatf("rand%0d", n));
            finishResp($sformatf("rand%0d", n));
        end
        req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
